texture_scan_loader: RTL and testbench

//  Sequences the texture-memory scan chain: takes (address, data) write requests on a valid/ready

---
 rtl/texture_scan_loader.sv | 124 ++++++++++++
 tb/tb_texture_scan_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_scan_loader.sv
// texture_scan_loader
//   Serialises (addr, data) texture writes onto the tiniest-gpu scan chain.
//   Each accepted request becomes a frame {1'b0, addr, data}, shifted out MSB
//   first. Every bit is framed by SETUP / PHI1 / GAP1 / PHI2 / GAP2, and a
//   one-cycle LOAD strobe ends the word.
// Ports
//   clk, rst_n           clock; reset (asynchronous, active-high)
//   req_valid/req_ready  request handshake; ready only in IDLE
//   req_addr, req_data   request payload, captured on accept
//   cnt_clr              synchronous clear of words_loaded / all_loaded
//   scan_data            serial chain data, stable from SETUP through GAP2
//   scan_phi1/scan_phi2  non-overlapping phase clocks
//   scan_load            end-of-word parallel-load strobe
//   busy                 high from the cycle after accept through LOAD
//   words_loaded         completed word count (wraps)
//   all_loaded           sticky, set when words_loaded reaches 2**ADDR_W
module texture_scan_loader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int PHI_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              cnt_clr,
  output logic              scan_data,
  output logic              scan_phi1,
  output logic              scan_phi2,
  output logic              scan_load,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              all_loaded
);

  localparam int B    = 1 + ADDR_W + DATA_W;
  localparam int BW   = $clog2(B);
  localparam int CMAX = (PHI_CYCLES > GAP_CYCLES) ? PHI_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]   PHI_LAST = CW'(PHI_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(B - 1);
  localparam logic [ADDR_W:0] WL_FULL_M1 = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PHI1, S_GAP1, S_PHI2, S_GAP2, S_LOAD
  } state_t;

  state_t state, state_d;

  // Only addr/data are held; the leading 0 of the frame is driven directly
  // on accept, so every stored bit is eventually shifted out.
  logic [B-2:0]  sr;
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] cnt;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (req_valid) state_d = S_SETUP;
      S_SETUP: state_d = S_PHI1;
      S_PHI1:  if (cnt == PHI_LAST) state_d = S_GAP1;
      S_GAP1:  if (cnt == GAP_LAST) state_d = S_PHI2;
      S_PHI2:  if (cnt == PHI_LAST) state_d = S_GAP2;
      S_GAP2:  if (cnt == GAP_LAST) state_d = (bit_idx == BIT_LAST) ? S_LOAD : S_SETUP;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they line up with the
  // state register while having no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      sr           <= '0;
      scan_data    <= 1'b0;
      scan_phi1    <= 1'b0;
      scan_phi2    <= 1'b0;
      scan_load    <= 1'b0;
      busy         <= 1'b0;
      req_ready    <= 1'b1;
      words_loaded <= '0;
      all_loaded   <= 1'b0;
    end else begin
      state     <= state_d;
      // dwell counter restarts on every state change
      cnt       <= (state_d != state) ? '0 : cnt + 1'b1;
      scan_phi1 <= (state_d == S_PHI1);
      scan_phi2 <= (state_d == S_PHI2);
      scan_load <= (state_d == S_LOAD);
      busy      <= (state_d != S_IDLE);
      req_ready <= (state_d == S_IDLE);

      if (state == S_IDLE && state_d == S_SETUP) begin
        sr        <= {req_addr, req_data};
        bit_idx   <= '0;
        scan_data <= 1'b0;
      end else if (state == S_GAP2 && state_d == S_SETUP) begin
        scan_data <= sr[B-2];
        sr        <= {sr[B-3:0], 1'b0};
        bit_idx   <= bit_idx + 1'b1;
      end else if (state == S_LOAD) begin
        scan_data <= 1'b0;
      end

      // clear beats a coincident LOAD increment
      if (cnt_clr) begin
        words_loaded <= '0;
        all_loaded   <= 1'b0;
      end else if (state == S_LOAD) begin
        words_loaded <= words_loaded + 1'b1;
        if (words_loaded == WL_FULL_M1) all_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_texture_scan_loader.sv
// Bench for texture_scan_loader: three instances (defaults; PHI=2; a narrow
// ADDR_W=4 / GAP=2 one for full-address-space and wrap coverage). A chain
// monitor rebuilds frames from phi1 samples and is compared against a
// queue of expected frames built from the request payloads.
module tb_texture_scan_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] vld, rdy, clr, sd, p1, p2, ld, bz, alld;
  logic [10:0] a_addr, b_addr;
  logic [3:0]  c_addr;
  logic [7:0]  a_data, b_data, c_data;
  logic [11:0] a_wl, b_wl;
  logic [4:0]  c_wl;

  always #5 clk = ~clk;

  texture_scan_loader u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_addr(a_addr), .req_data(a_data), .cnt_clr(clr[0]), .scan_data(sd[0]),
    .scan_phi1(p1[0]), .scan_phi2(p2[0]), .scan_load(ld[0]), .busy(bz[0]),
    .words_loaded(a_wl), .all_loaded(alld[0]));

  texture_scan_loader #(.PHI_CYCLES(2), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_addr(b_addr), .req_data(b_data), .cnt_clr(clr[1]), .scan_data(sd[1]),
    .scan_phi1(p1[1]), .scan_phi2(p2[1]), .scan_load(ld[1]), .busy(bz[1]),
    .words_loaded(b_wl), .all_loaded(alld[1]));

  texture_scan_loader #(.ADDR_W(4), .PHI_CYCLES(1), .GAP_CYCLES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_addr(c_addr), .req_data(c_data), .cnt_clr(clr[2]), .scan_data(sd[2]),
    .scan_phi1(p1[2]), .scan_phi2(p2[2]), .scan_load(ld[2]), .busy(bz[2]),
    .words_loaded(c_wl), .all_loaded(alld[2]));

  int PHI[3] = '{1, 2, 1};
  int GAP[3] = '{1, 1, 2};
  int AW[3]  = '{11, 11, 4};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int nbits(input int k);
    return 1 + AW[k] + 8;
  endfunction

  function automatic int wt(input int k);
    return nbits(k) * (1 + 2 * PHI[k] + 2 * GAP[k]) + 1;
  endfunction

  function automatic logic [19:0] mkframe(input int k, input logic [10:0] a, input logic [7:0] d);
    if (k == 2) return {8'b0, a[3:0], d};
    return {1'b0, a, d};
  endfunction

  function automatic logic [31:0] get_wl(input int k);
    case (k)
      0: return 32'(a_wl);
      1: return 32'(b_wl);
      default: return 32'(c_wl);
    endcase
  endfunction

  // ---------------- chain monitor ----------------
  logic [19:0] cur[3];
  int nb[3], r1[3], r2[3];
  logic pp1[3], pp2[3];
  int badw[3], ovl[3], ldphi[3], idlephi[3], unst[3], sdidle[3], bzerr[3], npulse[3];
  logic [19:0] frm[3][64];
  int nbit[3][64], ldc[3][64], fr_cnt[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      cur[k] = '0; nb[k] = 0; r1[k] = 0; r2[k] = 0; pp1[k] = 0; pp2[k] = 0;
      badw[k] = 0; ovl[k] = 0; ldphi[k] = 0; idlephi[k] = 0; unst[k] = 0;
      sdidle[k] = 0; bzerr[k] = 0; npulse[k] = 0; fr_cnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pp1[k] <= p1[k];
      pp2[k] <= p2[k];
      assert (!(p1[k] && p2[k])) else ovl[k] <= ovl[k] + 1;
      if (rst_n) begin
        cur[k] <= '0; nb[k] <= 0; r1[k] <= 0; r2[k] <= 0;
      end else begin
        if (p1[k] && !pp1[k]) begin
          cur[k] <= {cur[k][18:0], sd[k]};
          nb[k]  <= nb[k] + 1;
        end
        if (p2[k] && !pp2[k] && sd[k] !== cur[k][0]) unst[k] <= unst[k] + 1;
        if (ld[k] && (p1[k] || p2[k])) ldphi[k] <= ldphi[k] + 1;
        if (rdy[k] && (p1[k] || p2[k])) idlephi[k] <= idlephi[k] + 1;
        if (rdy[k] && sd[k]) sdidle[k] <= sdidle[k] + 1;
        if (bz[k] === rdy[k]) bzerr[k] <= bzerr[k] + 1;
        if (p1[k]) r1[k] <= r1[k] + 1;
        else if (r1[k] != 0) begin
          if (r1[k] != PHI[k]) badw[k] <= badw[k] + 1;
          npulse[k] <= npulse[k] + 1;
          r1[k] <= 0;
        end
        if (p2[k]) r2[k] <= r2[k] + 1;
        else if (r2[k] != 0) begin
          if (r2[k] != PHI[k]) badw[k] <= badw[k] + 1;
          npulse[k] <= npulse[k] + 1;
          r2[k] <= 0;
        end
        if (ld[k] && fr_cnt[k] < 64) begin
          frm[k][fr_cnt[k]]  <= cur[k];
          nbit[k][fr_cnt[k]] <= nb[k];
          ldc[k][fr_cnt[k]]  <= cyc;
          fr_cnt[k] <= fr_cnt[k] + 1;
          cur[k] <= '0;
          nb[k]  <= 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          k;
    logic [19:0] frame;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   wl_m[3]   = '{0, 0, 0};
  bit   all_m[3]  = '{0, 0, 0};
  bit   clrwin[3] = '{0, 0, 0};
  int   done[3]   = '{0, 0, 0};

  task automatic set_req(input int k, input logic [10:0] a, input logic [7:0] d);
    case (k)
      0: begin a_addr = a; a_data = d; end
      1: begin b_addr = a; b_data = d; end
      default: begin c_addr = a[3:0]; c_data = d; end
    endcase
  endtask

  // Offer a request; while the block is busy, valid either stays high with
  // the real payload (hold) or toggles with junk. Returns with valid still
  // high when hold is set.
  task automatic send(input int k, input logic [10:0] a, input logic [7:0] d,
                      input int idle, input bit hold, output int acc);
    int t = 0;
    repeat (idle) begin @(negedge clk); vld[k] = 1'b0; end
    @(negedge clk);
    while (!rdy[k] && t < 400) begin
      if (hold) begin vld[k] = 1'b1; set_req(k, a, d); end
      else begin vld[k] = 1'($urandom); set_req(k, 11'($urandom), 8'($urandom)); end
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("accept_timeout", 32'(t), 0);
    vld[k] = 1'b1;
    set_req(k, a, d);
    acc = cyc;
    expq.push_back('{k, mkframe(k, a, d), acc});
    @(negedge clk);
    if (!hold) vld[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    int target = done[k] + expq.size();
    while (fr_cnt[k] < target && t < 3000) begin @(posedge clk); t++; end
    if (t >= 3000) chk("done_timeout", 32'(fr_cnt[k]), 32'(target));
    while (done[k] < fr_cnt[k] && expq.size() > 0) begin
      exp_t e = expq.pop_front();
      int i = done[k];
      chk("frame", 32'(frm[k][i]), 32'(e.frame));
      chk("frame_bits", 32'(nbit[k][i]), 32'(nbits(k)));
      chk("word_time", 32'(ldc[k][i] - e.acc), 32'(wt(k)));
      wl_m[k] = (wl_m[k] + 1) % (1 << (AW[k] + 1));
      if (wl_m[k] == (1 << AW[k])) all_m[k] = 1'b1;
      done[k]++;
    end
    if (clrwin[k]) begin wl_m[k] = 0; all_m[k] = 1'b0; clrwin[k] = 1'b0; end
    @(negedge clk);
    chk("words_loaded", get_wl(k), 32'(wl_m[k]));
    chk("all_loaded", 32'(alld[k]), 32'(all_m[k]));
  endtask

  task automatic send_clr_in_load(input int k, input logic [10:0] a, input logic [7:0] d);
    int acc;
    int t = 0;
    send(k, a, d, 0, 1'b0, acc);
    while (!ld[k] && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) chk("load_timeout", 32'(t), 0);
    clr[k] = 1'b1;
    clrwin[k] = 1'b1;
    @(negedge clk);
    clr[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, saved, t;
    rst_n = 1'b1; vld = '0; clr = '0;
    a_addr = '0; b_addr = '0; c_addr = '0; a_data = '0; b_data = '0; c_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdy), 32'h7);
    chk("reset_outs", 32'({sd, p1, p2, ld, bz, alld}), 0);
    chk("reset_wl", get_wl(0) | get_wl(1) | get_wl(2), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // test 1: single word 0x000/0xA5
    send(0, 11'h000, 8'hA5, 0, 1'b0, acc1);
    wait_done(0);

    // test 2: back-to-back with valid held high
    send(0, 11'h7FF, 8'hFF, 0, 1'b1, acc1);
    send(0, 11'h001, 8'h3C, 0, 1'b1, acc2);
    vld[0] = 1'b0;
    chk("b2b_spacing", 32'(acc2 - acc1), 32'(wt(0) + 1));
    wait_done(0);

    // test 4: reset in the middle of a word
    send(0, 11'h123, 8'h5A, 0, 1'b0, acc1);
    void'(expq.pop_back());
    t = 0;
    while (nb[0] < 7 && t < 400) begin @(posedge clk); t++; end
    if (t >= 400) chk("bit7_timeout", 32'(t), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst4_ready", 32'(rdy[0]), 1);
    chk("rst4_outs", 32'({sd[0], p1[0], p2[0], ld[0], bz[0], alld[0]}), 0);
    chk("rst4_wl", get_wl(0), 0);
    for (int k = 0; k < 3; k++) begin wl_m[k] = 0; all_m[k] = 1'b0; end
    saved = fr_cnt[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (120) @(negedge clk);
    chk("rst4_no_load", 32'(fr_cnt[0]), 32'(saved));
    chk("rst4_wl_after", get_wl(0), 0);
    send(0, 11'h2C4, 8'h96, 0, 1'b0, acc1);
    wait_done(0);

    // randomized words with idle gaps and junk valid toggling
    for (int i = 0; i < 6; i++) begin
      send(0, 11'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b0, acc1);
      if ($urandom_range(0, 1) == 1) send(0, 11'($urandom), 8'($urandom), 0, 1'b0, acc1);
      wait_done(0);
    end

    // test 6: clear coinciding with LOAD, then one more word
    send_clr_in_load(0, 11'($urandom), 8'($urandom));
    send(0, 11'($urandom), 8'($urandom), 0, 1'b0, acc1);
    wait_done(0);
    chk("clr6_next", get_wl(0), 1);

    // test 3: two-cycle phase pulses
    for (int i = 0; i < 2; i++) begin
      send(1, 11'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0, acc1);
      wait_done(1);
    end
    repeat (2) @(negedge clk);
    chk("b_pulse_count", 32'(npulse[1]), 32'(2 * 2 * nbits(1)));

    // test 5 on the narrow instance: full address space, clear-in-LOAD at
    // the filling word, fill, wrap, then an idle clear
    for (int i = 0; i < 15; i++) begin
      send(2, 11'(i), 8'(i), 0, 1'b0, acc1);
      wait_done(2);
    end
    send_clr_in_load(2, 11'd15, 8'd15);
    for (int i = 0; i < 32; i++) begin
      send(2, 11'(i), 8'(i), $urandom_range(0, 2), 1'b0, acc1);
      wait_done(2);
      if (i == 15) chk("c_full_wl", get_wl(2), 16);
    end
    chk("c_wrap_wl", get_wl(2), 0);
    chk("c_sticky_all", 32'(alld[2]), 1);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    wl_m[2] = 0; all_m[2] = 1'b0;
    chk("c_clr_wl", get_wl(2), 32'(wl_m[2]));
    chk("c_clr_all", 32'(alld[2]), 32'(all_m[2]));

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("phase_overlap", 32'(ovl[k]), 0);
      chk("phase_width", 32'(badw[k]), 0);
      chk("phase_in_load", 32'(ldphi[k]), 0);
      chk("phase_in_idle", 32'(idlephi[k]), 0);
      chk("data_unstable", 32'(unst[k]), 0);
      chk("data_in_idle", 32'(sdidle[k]), 0);
      chk("busy_vs_ready", 32'(bzerr[k]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
